ctl_status_writer: RTL and testbench
====================================

// Module: ctl_status_writer
// PURPOSE
//  FPGA-side writer into the controller BRAM register page read by the CPU. After reset it publishes
//  VERSION_NUM_MAJOR/MINOR once, then rewrites FPGA_STATE whenever the live status bits change.
//  Shares the controller BRAM port with the controller config reader through a REQ/GNT handshake.
//  Sits between the status sources (thermo, mod/stm timing) and the controller BRAM write port.
// PARAMETERS
//  VersionMajor   8'h90  value written to ADDR_VERSION_NUM_MAJOR (low byte, high byte 0)
//  VersionMinor   8'h00  value written to ADDR_VERSION_NUM_MINOR (low byte, high byte 0)
//  RefreshCycles  20480  forced FPGA_STATE rewrite period in CLK cycles (only with the _EN macro)
// PORTS
//  CLK          in   1   system clock
//  RESETN       in   1   synchronous reset, active-low
//  THERMO       in   1   thermal alarm level
//  MOD_SEGMENT  in   1   current modulation read segment
//  STM_SEGMENT  in   1   current STM read segment
//  IS_STM_MODE  in   1   STM output active
//  BUS_GNT      in   1   controller BRAM port granted to this block
//  BUS_REQ      out  1   request for controller BRAM port
//  WE           out  1   BRAM write enable, one cycle per write
//  ADDR         out  8   BRAM word address (ADDR_* of controller page)
//  DIN          out  16  BRAM write data
//  BUSY         out  1   high in any state other than IDLE
// BEHAVIOUR
//  - All outputs registered. Reset (RESETN=0 at a CLK edge): BUS_REQ=0 WE=0 ADDR=0 DIN=0 BUSY=1,
//    state=INIT_MAJOR, last_state=8'h00. Reset mid-write aborts; outputs at reset values next cycle.
//  - State word S = {8'h00, 1'b1, 3'b000, IS_STM_MODE, STM_SEGMENT, MOD_SEGMENT, THERMO}; bit7 marks
//    "FPGA state valid" so the CPU distinguishes it from the BRAM power-on zero.
//  - FSM: INIT_MAJOR -> INIT_MINOR -> IDLE; IDLE -> REQ on pending write; REQ -> WR on BUS_GNT;
//    WR -> IDLE (or next INIT_*). Each of INIT_MAJOR/INIT_MINOR internally runs REQ/WR sub-phases.
//  - Handshake: BUS_REQ rises the cycle after a write becomes pending and stays high until WR ends.
//    BUS_GNT sampled high in cycle n -> WE=1, ADDR, DIN valid in cycle n+1 (BUS_REQ still 1).
//    Cycle n+2: WE=0, BUS_REQ=0. BUS_REQ low for >=1 cycle between consecutive writes.
//  - BUS_GNT while BUS_REQ=0 ignored. BUS_GNT dropped before sampling high: keep waiting, no timeout.
//  - Write data: INIT_MAJOR -> ADDR 8'h02, DIN {8'h00,VersionMajor}; INIT_MINOR -> ADDR 8'h03,
//    DIN {8'h00,VersionMinor}; state write -> ADDR 8'h01, DIN = S snapshot taken in the GNT cycle.
//  - Pending state write: in IDLE when S[7:0] != last_state; last_state <= snapshot on WE cycle.
//    Inputs toggling during REQ: snapshot at GNT wins; a later change re-arms from IDLE.
//    First pass after INIT always writes (last_state reset 0 has bit7=0).
//  - Latency: input change -> BUS_REQ 2 cycles (sample + IDLE compare); GNT -> WE 1 cycle.
//  - Inputs are assumed synchronous to CLK; no internal synchronisers.
// CONFIGURATION
//  CTL_STATUS_PERIODIC_REFRESH_EN defined: a counter runs 0..RefreshCycles-1 from reset release;
//    on wrap a refresh flag is set, which makes IDLE issue a state write even if unchanged; flag
//    cleared on the WE of any state write. Counter keeps running during REQ/WR.
//  Not defined: no counter or flag; FPGA_STATE written only on change; RefreshCycles unused.
// TESTING
//  1 Reset release, BUS_GNT tied 1 -> WE at ADDR 02 DIN 0090, then 03 DIN 0000, then 01 DIN 0080.
//  2 IDLE, THERMO 0->1, GNT tied 1 -> BUS_REQ 2 cycles later, one WE ADDR 01 DIN 0081, no repeat.
//  3 GNT held 0 for 50 cycles while MOD_SEGMENT toggles 1->0->1 -> one WE after GNT with snapshot
//    value at GNT cycle; BUS_REQ stays 1 throughout, WE=0 throughout the wait.
//  4 Assert RESETN=0 in the WE cycle of the state write -> next cycle WE=0 BUS_REQ=0; init re-runs.
//  5 BUS_GNT pulses while idle and unchanged -> no WE, BUS_REQ stays 0.
//  6 _EN defined, RefreshCycles=100, inputs static -> WE ADDR 01 same DIN every 100 cycles (+-3);
//    undefined -> no further writes.

Source files
------------

// File: rtl/ctl_status_writer_if.sv
// Controller BRAM write port shared with the config reader via REQ/GNT.
// The writer drives the request and write strobes; the arbiter drives the grant.
interface ctl_status_writer_if;
    logic        BUS_REQ;
    logic        BUS_GNT;
    logic        WE;
    logic [7:0]  ADDR;
    logic [15:0] DIN;
    logic        BUSY;

    modport master (
        output BUS_REQ,
        output WE,
        output ADDR,
        output DIN,
        output BUSY,
        input  BUS_GNT
    );

    modport slave (
        input  BUS_REQ,
        input  WE,
        input  ADDR,
        input  DIN,
        input  BUSY,
        output BUS_GNT
    );
endinterface

// File: rtl/ctl_status_writer.sv
// Publishes version words once after reset, then FPGA_STATE on every status change.
// Optional periodic FPGA_STATE rewrite: CTL_STATUS_PERIODIC_REFRESH_EN.
module ctl_status_writer #(
    parameter logic [7:0] VersionMajor = 8'h90,
    parameter logic [7:0] VersionMinor = 8'h00
`ifdef CTL_STATUS_PERIODIC_REFRESH_EN
    ,
    parameter int unsigned RefreshCycles = 20480
`endif
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       THERMO,
    input  logic                       MOD_SEGMENT,
    input  logic                       STM_SEGMENT,
    input  logic                       IS_STM_MODE,
    ctl_status_writer_if.master        bus
);

    localparam logic [7:0] AddrState = 8'h01;
    localparam logic [7:0] AddrMajor = 8'h02;
    localparam logic [7:0] AddrMinor = 8'h03;

    typedef enum logic [2:0] {
        ST_INIT_MAJOR,
        ST_INIT_MINOR,
        ST_IDLE,
        ST_REQ,
        ST_WR
    } state_e;

    typedef enum logic [1:0] {
        K_MAJOR,
        K_MINOR,
        K_STATE
    } kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  last_q, last_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        busy_q, busy_d;
    logic [7:0]  s_live;
    logic        refresh;

    // bit7 tells the CPU the word came from the FPGA, not BRAM power-on zero
    assign s_live = {1'b1, 3'b000, IS_STM_MODE, STM_SEGMENT,
                     MOD_SEGMENT, THERMO};

`ifdef CTL_STATUS_PERIODIC_REFRESH_EN
    localparam int unsigned CntW =
        (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            refresh_q, refresh_d;
    logic            wrap;
    logic            state_wr_done;

    assign wrap = (cnt_q == CntW'(RefreshCycles - 1));
    assign state_wr_done = (state_q == ST_WR) && (kind_q == K_STATE);

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        refresh_d = wrap | (refresh_q & ~state_wr_done);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q     <= '0;
            refresh_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            refresh_q <= refresh_d;
        end
    end

    assign refresh = refresh_q;
`else
    assign refresh = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        s_d     = s_live;
        last_d  = last_q;
        req_d   = req_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        unique case (state_q)
            ST_INIT_MAJOR: begin
                kind_d  = K_MAJOR;
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_INIT_MINOR: begin
                kind_d  = K_MINOR;
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_IDLE: begin
                if ((s_q != last_q) || refresh) begin
                    kind_d  = K_STATE;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.BUS_GNT) begin
                    we_d    = 1'b1;
                    state_d = ST_WR;
                    unique case (kind_q)
                        K_MAJOR: begin
                            addr_d = AddrMajor;
                            din_d  = {8'h00, VersionMajor};
                        end
                        K_MINOR: begin
                            addr_d = AddrMinor;
                            din_d  = {8'h00, VersionMinor};
                        end
                        default: begin
                            addr_d = AddrState;
                            din_d  = {8'h00, s_live};
                        end
                    endcase
                end
            end
            ST_WR: begin
                req_d = 1'b0;
                if (kind_q == K_STATE) begin
                    last_d = din_q[7:0];
                end
                // version writes chain through INIT_* so REQ drops a cycle
                unique case (kind_q)
                    K_MAJOR: state_d = ST_INIT_MINOR;
                    default: state_d = ST_IDLE;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_INIT_MAJOR;
            kind_q  <= K_MAJOR;
            s_q     <= 8'h00;
            last_q  <= 8'h00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            din_q   <= 16'h0000;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            s_q     <= s_d;
            last_q  <= last_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.BUS_REQ = req_q;
    assign bus.WE      = we_q;
    assign bus.ADDR    = addr_q;
    assign bus.DIN     = din_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_ctl_status_writer.sv
// Bench for ctl_status_writer: write scoreboard plus handshake checks.
// Directed scenarios cover init, change, long wait, reset abort, stray GNT, refresh.
module tb_ctl_status_writer;

    logic clk;
    logic rst_n;
    logic thermo;
    logic mod_seg;
    logic stm_seg;
    logic stm_mode;
    int   checks;
    int   errors;
    int   cyc;
    logic [7:0] exp_q[$];

    ctl_status_writer_if bus ();

`ifdef CTL_STATUS_PERIODIC_REFRESH_EN
    ctl_status_writer #(
        .RefreshCycles(100)
    ) dut (
        .CLK         (clk),
        .RESETN      (rst_n),
        .THERMO      (thermo),
        .MOD_SEGMENT (mod_seg),
        .STM_SEGMENT (stm_seg),
        .IS_STM_MODE (stm_mode),
        .bus         (bus.master)
    );
`else
    ctl_status_writer dut (
        .CLK         (clk),
        .RESETN      (rst_n),
        .THERMO      (thermo),
        .MOD_SEGMENT (mod_seg),
        .STM_SEGMENT (stm_seg),
        .IS_STM_MODE (stm_mode),
        .bus         (bus.master)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sword();
        return {1'b1, 3'b000, stm_mode, stm_seg, mod_seg, thermo};
    endfunction

    function automatic logic [15:0] exp_din(input logic [7:0] a,
                                            input logic [7:0] s);
        if (a == 8'h02) return 16'h0090;
        if (a == 8'h03) return 16'h0000;
        return {8'h00, s};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard: every WE pops one expected address; state data is the
    // status word present on the edge where the grant was taken.
    initial begin
        logic       rst_e;
        logic       gnt_e;
        logic       we_n;
        logic       req_n;
        logic [7:0] s_e;
        logic [7:0] a;
        we_n  = 1'b0;
        req_n = 1'b0;
        forever begin
            @(posedge clk);
            rst_e = rst_n;
            gnt_e = bus.BUS_GNT;
            s_e   = sword();
            @(negedge clk);
            if (!rst_e) begin
                chk("rst_we", 32'(bus.WE), 32'h0);
                chk("rst_req", 32'(bus.BUS_REQ), 32'h0);
                chk("rst_addr", 32'(bus.ADDR), 32'h0);
                chk("rst_din", 32'(bus.DIN), 32'h0);
                chk("rst_busy", 32'(bus.BUSY), 32'h1);
            end else begin
                chk("we_timing", 32'(bus.WE),
                    32'(req_n & gnt_e & ~we_n));
                if (we_n) chk("req_gap", 32'(bus.BUS_REQ), 32'h0);
                if (bus.BUS_REQ | bus.WE)
                    chk("busy_active", 32'(bus.BUSY), 32'h1);
                if (bus.WE) begin
                    chk("we_with_req", 32'(bus.BUS_REQ), 32'h1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_we actual addr %h din %h required no write",
                                 bus.ADDR, bus.DIN);
                    end else begin
                        a = exp_q.pop_front();
                        if (bus.ADDR !== a) begin
                            errors++;
                            $display("FAIL sb_addr actual %h required %h",
                                     bus.ADDR, a);
                        end
                        chk("sb_din", 32'(bus.DIN), 32'(exp_din(a, s_e)));
                    end
                end
            end
            we_n  = bus.WE;
            req_n = bus.BUS_REQ;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_we(input string nm, input int maxc, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (bus.WE) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s actual no WE in %0d cycles required WE", nm, maxc);
        end
    endtask

    task automatic reset_apply();
        step(1);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic init_seq(input logic [7:0] s);
        int t;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h01);
        wait_we("init_major_we", 10, t);
        chk("init_major_addr", 32'(bus.ADDR), 32'h02);
        chk("init_major_din", 32'(bus.DIN), 32'h0090);
        wait_we("init_minor_we", 10, t);
        chk("init_minor_addr", 32'(bus.ADDR), 32'h03);
        chk("init_minor_din", 32'(bus.DIN), 32'h0000);
        wait_we("init_state_we", 10, t);
        chk("init_state_addr", 32'(bus.ADDR), 32'h01);
        chk("init_state_din", 32'(bus.DIN), 32'({8'h00, s}));
    endtask

    initial begin
        int t;
        int t0;
        int t1;
        int t2;
        int lat;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        thermo      = 1'b0;
        mod_seg     = 1'b0;
        stm_seg     = 1'b0;
        stm_mode    = 1'b0;
        bus.BUS_GNT = 1'b1;

        // 1: init sequence with grant tied high
        reset_apply();
        init_seq(8'h80);
        step(3);
        chk("t1_idle_busy", 32'(bus.BUSY), 32'h0);
        chk("t1_idle_req", 32'(bus.BUS_REQ), 32'h0);

        // 2: single status change
        exp_q.push_back(8'h01);
        thermo = 1'b1;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!bus.BUS_REQ && lat < 10);
        chk("t2_req_latency", 32'(lat), 32'd2);
        wait_we("t2_we", 5, t);
        chk("t2_addr", 32'(bus.ADDR), 32'h01);
        chk("t2_din", 32'(bus.DIN), 32'h0081);
        step(10);
        chk("t2_no_repeat_req", 32'(bus.BUS_REQ), 32'h0);
        chk("t2_busy", 32'(bus.BUSY), 32'h0);

        // 3: grant withheld while the status toggles
        reset_apply();
        init_seq(8'h81);
        step(1);
        bus.BUS_GNT = 1'b0;
        mod_seg = 1'b1;
        exp_q.push_back(8'h01);
        step(2);
        for (int i = 0; i < 50; i++) begin
            chk("t3_req_held", 32'(bus.BUS_REQ), 32'h1);
            chk("t3_we_low", 32'(bus.WE), 32'h0);
            if (i == 15) mod_seg = 1'b0;
            if (i == 30) mod_seg = 1'b1;
            step(1);
        end
        bus.BUS_GNT = 1'b1;
        stm_seg = 1'b1;
        wait_we("t3_we", 5, t);
        chk("t3_din_snapshot", 32'(bus.DIN), 32'h0087);
        step(5);
        chk("t3_req_after", 32'(bus.BUS_REQ), 32'h0);

        // 4: reset lands in the WE cycle
        exp_q.push_back(8'h01);
        thermo = 1'b0;
        wait_we("t4_we", 6, t);
        chk("t4_din", 32'(bus.DIN), 32'h0086);
        rst_n = 1'b0;
        step(1);
        chk("t4_abort_we", 32'(bus.WE), 32'h0);
        chk("t4_abort_req", 32'(bus.BUS_REQ), 32'h0);
        step(1);
        rst_n = 1'b1;
        init_seq(8'h86);

        // 5: stray grant pulses while idle and unchanged
        step(1);
        bus.BUS_GNT = 1'b0;
        step(3);
        for (int k = 0; k < 4; k++) begin
            bus.BUS_GNT = 1'b1;
            step(1);
            bus.BUS_GNT = 1'b0;
            chk("t5_req_low", 32'(bus.BUS_REQ), 32'h0);
            step(2);
            chk("t5_req_still_low", 32'(bus.BUS_REQ), 32'h0);
            chk("t5_we_low", 32'(bus.WE), 32'h0);
        end

        // 6: static inputs, periodic rewrite only when enabled
        bus.BUS_GNT = 1'b1;
        reset_apply();
        init_seq(8'h86);
`ifdef CTL_STATUS_PERIODIC_REFRESH_EN
        exp_q.push_back(8'h01);
        wait_we("t6_refresh1", 130, t0);
        chk("t6_din1", 32'(bus.DIN), 32'h0086);
        exp_q.push_back(8'h01);
        wait_we("t6_refresh2", 130, t1);
        chk("t6_din2", 32'(bus.DIN), 32'h0086);
        exp_q.push_back(8'h01);
        wait_we("t6_refresh3", 130, t2);
        chk("t6_din3", 32'(bus.DIN), 32'h0086);
        checks++;
        if ((t1 - t0) < 97 || (t1 - t0) > 103) begin
            errors++;
            $display("FAIL t6_period1 actual %0d required 100+-3", t1 - t0);
        end
        checks++;
        if ((t2 - t1) < 97 || (t2 - t1) > 103) begin
            errors++;
            $display("FAIL t6_period2 actual %0d required 100+-3", t2 - t1);
        end
`else
        t0 = 0;
        t1 = 0;
        t2 = 0;
        step(250);
        chk("t6_no_refresh_req", 32'(bus.BUS_REQ), 32'h0);
        chk("t6_no_refresh_busy", 32'(bus.BUSY), 32'h0);
`endif
        step(2);
        chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
